// File: rtl/rom_loader_pkg.sv
// Shared project constants: program memory geometry and loader stream parameters.
// Helper to turn a word index into a program-memory byte address.
package rom_loader_pkg;

  localparam int WORDS_DEFAULT         = 256;
  localparam int ADDRESS_WIDTH_DEFAULT = 10;

  localparam int          BYTES_PER_WORD  = 4;
  localparam int          WORD_ADDR_SHIFT = 2;
  localparam logic [31:0] PROG_MEM_BASE   = 32'h0000_0000;
  localparam logic [31:0] PROG_MEM_BYTES  = 32'(WORDS_DEFAULT * BYTES_PER_WORD);

  localparam int COUNT_WIDTH    = 16;
  localparam int CHECKSUM_WIDTH = 8;

  typedef logic [COUNT_WIDTH-1:0]    word_count_t;
  typedef logic [CHECKSUM_WIDTH-1:0] checksum_t;

  function automatic logic [31:0] word_to_byte_addr(input word_count_t idx);
    return PROG_MEM_BASE + ({16'b0, idx} << WORD_ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and program-memory write port of the ROM loader.
// master is the loader side; slave is the front end / memory side.
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) ();

  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [ADDRESS_WIDTH-1:0] mem_address;
  logic [31:0]              mem_data;
  logic                     mem_write_enable;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output mem_address,
    output mem_data,
    output mem_write_enable
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  mem_address,
    input  mem_data,
    input  mem_write_enable
  );

endinterface

// File: rtl/rom_loader.sv
// Loads a length-prefixed, checksummed byte stream into program memory as
// little-endian 32-bit words, one write cycle per assembled word.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int WORDS         = WORDS_DEFAULT,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  rom_loader_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  word_count_t              r_count;
  word_count_t              r_word_idx;
  logic [1:0]               r_byte_idx;
  checksum_t                r_checksum;
  logic [23:0]              r_word_lo;
  logic [ADDRESS_WIDTH-1:0] r_mem_address;
  logic [31:0]              r_mem_data;

  logic        w_rx_ready;
  logic        w_mem_write_enable;
  logic        w_busy;
  logic        w_done;
  logic        w_error;
  logic        w_xfer;
  logic        w_can_start;
  word_count_t w_count_full;
  word_count_t w_word_idx_inc;
  logic        w_count_too_big;

  assign w_xfer          = bus.rx_valid & w_rx_ready;
  assign w_can_start     = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
  assign w_count_full    = {bus.rx_data, r_count[7:0]};
  assign w_word_idx_inc  = r_word_idx + word_count_t'(1);
  assign w_count_too_big = ({16'b0, w_count_full} > 32'(WORDS));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_xfer) w_state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          if (w_count_too_big)           w_state_next = S_ERROR;
          else if (w_count_full == '0)   w_state_next = S_CHECK;
          else                           w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && (r_byte_idx == 2'd3)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_word_idx_inc == r_count) w_state_next = S_CHECK;
        else                           w_state_next = S_DATA;
      end
      S_CHECK: begin
        if (w_xfer) begin
          if (bus.rx_data == r_checksum) w_state_next = S_DONE;
          else                           w_state_next = S_ERROR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_ready         = 1'b0;
    w_mem_write_enable = 1'b0;
    w_busy             = 1'b0;
    w_done             = 1'b0;
    w_error            = 1'b0;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
      end
      S_WRITE: begin
        w_mem_write_enable = 1'b1;
        w_busy             = 1'b1;
      end
      S_CHECK: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
      end
      S_DONE:  w_done  = 1'b1;
      S_ERROR: w_error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length capture, byte assembly, checksum and write-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count       <= '0;
      r_word_idx    <= '0;
      r_byte_idx    <= '0;
      r_checksum    <= '0;
      r_word_lo     <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_can_start) begin
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_checksum <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) r_count[7:0] <= bus.rx_data;
        end
        S_LEN_HI: begin
          if (w_xfer) r_count[15:8] <= bus.rx_data;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_checksum <= r_checksum + bus.rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word_lo[7:0]   <= bus.rx_data;
              2'd1: r_word_lo[15:8]  <= bus.rx_data;
              2'd2: r_word_lo[23:16] <= bus.rx_data;
              default: begin
                // Last byte goes straight to the write port, ready for WRITE.
                r_mem_data    <= {bus.rx_data, r_word_lo};
                r_mem_address <= ADDRESS_WIDTH'(word_to_byte_addr(r_word_idx));
              end
            endcase
          end
        end
        S_WRITE: r_word_idx <= w_word_idx_inc;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready         = w_rx_ready;
  assign bus.mem_write_enable = w_mem_write_enable;
  assign bus.mem_address      = r_mem_address;
  assign bus.mem_data         = r_mem_data;
  assign busy                 = w_busy;
  assign done                 = w_done;
  assign error                = w_error;

endmodule
